// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution MAC engine and its
// downstream stages.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Wide enough that summing ntap full-width signed products never overflows.
  function automatic int acc_width(input int data_w, input int coef_w, input int ntap);
    return data_w + coef_w + clog2(ntap);
  endfunction

endpackage

// File: rtl/conv_shift_sat.sv
// Combinational arithmetic right shift (floor) followed by signed saturation
// to OUT_W bits; shared with the activation stage.
module conv_shift_sat #(
  parameter int ACC_W = 20,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  // One spare bit so both the shifted value and the output bounds fit signed.
  localparam int CW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [CW-1:0] MAX_V = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] MIN_V = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic signed [CW-1:0]    wide;

  assign shifted = acc >>> SHIFT;
  assign wide    = CW'(shifted);

  always_comb begin
    out_data = wide[OUT_W-1:0];
    out_sat  = 1'b0;
    if (wide > MAX_V) begin
      out_data = {1'b0, {(OUT_W-1){1'b1}}};
      out_sat  = 1'b1;
    end else if (wide < MIN_V) begin
      out_data = {1'b1, {(OUT_W-1){1'b0}}};
      out_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: time-multiplexed KxK signed convolution MAC, LANES taps per cycle,
// then shift/saturate. Build macro CONV_BIAS_EN adds a bias port seeding the accumulator.
module conv_mac_seq
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int K      = 3,
  parameter int LANES  = 1,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [K*K*DATA_W-1:0]    pix_flat,
  input  logic [K*K*COEF_W-1:0]    coef_flat,
`ifdef CONV_BIAS_EN
  input  logic [COEF_W+DATA_W-1:0] bias,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int NTAP   = K * K;
  localparam int NT     = NTAP / LANES;
  localparam int PROD_W = DATA_W + COEF_W;
`ifdef CONV_BIAS_EN
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAP) + 1;
`else
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAP);
`endif
  localparam int CNT_W  = clog2(NT + 1);

  if (NTAP % LANES != 0) begin : g_lanes_check
    $error("conv_mac_seq: LANES must divide K*K");
  end

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [NTAP*DATA_W-1:0]   pix_q, pix_d;
  logic [NTAP*COEF_W-1:0]   coef_q, coef_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;

  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  acc_init;
  logic [OUT_W-1:0]         sat_data;
  logic                     sat_flag;

  // Lane l of step cnt multiplies tap cnt*LANES + l.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int tap;
    assign tap     = int'(cnt_q) * LANES + l;
    assign prod[l] = PROD_W'($signed(pix_q[tap*DATA_W +: DATA_W])) *
                     PROD_W'($signed(coef_q[tap*COEF_W +: COEF_W]));
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + ACC_W'(prod[l]);
    end
  end

  assign acc_next = acc_q + lane_sum;

`ifdef CONV_BIAS_EN
  assign acc_init = ACC_W'($signed(bias));
`else
  assign acc_init = '0;
`endif

  conv_shift_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_shift_sat (
    .acc      (acc_next),
    .out_data (sat_data),
    .out_sat  (sat_flag)
  );

  // Handshakes: a transfer occurs on a rising clk edge where valid && ready;
  // valid never drops and data never changes until that transfer happens.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    pix_d       = pix_q;
    coef_d      = coef_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pix_d      = pix_flat;
          coef_d     = coef_flat;
          acc_d      = acc_init;
          cnt_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NT - 1)) begin
          state_d     = DONE;
          out_data_d  = sat_data;
          out_sat_d   = sat_flag;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      pix_q       <= '0;
      coef_q      <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      pix_q       <= pix_d;
      coef_q      <= coef_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_mac_seq.sv
// Bench for conv_mac_seq: dut0 uses default parameters, dut1 uses LANES=3,
// SHIFT=2, OUT_W=12; results are checked against a floor-divide/clip model.
module tb_conv_mac_seq;

  localparam int NTAP = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]        in_valid;
  logic [1:0]        out_ready;
  logic [NTAP*8-1:0] pix_flat;
  logic [NTAP*8-1:0] coef_flat;
  wire  [1:0]        in_ready;
  wire  [1:0]        out_valid;
  wire  [1:0]        out_sat;
  wire  [1:0]        busy;
  wire  [15:0]       out_data0;
  wire  [11:0]       out_data1;
`ifdef CONV_BIAS_EN
  logic [15:0]       bias;
`endif

  int          px [NTAP];
  int          cf [NTAP];
  int          cfa [NTAP];
  int          cfb [NTAP];
  longint      bias_v;
  logic [16:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  conv_mac_seq #(
    .DATA_W(8), .COEF_W(8), .K(3), .LANES(1), .OUT_W(16), .SHIFT(0)
  ) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .pix_flat  (pix_flat),
    .coef_flat (coef_flat),
`ifdef CONV_BIAS_EN
    .bias      (bias),
`endif
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data0),
    .out_sat   (out_sat[0]),
    .busy      (busy[0])
  );

  conv_mac_seq #(
    .DATA_W(8), .COEF_W(8), .K(3), .LANES(3), .OUT_W(12), .SHIFT(2)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .pix_flat  (pix_flat),
    .coef_flat (coef_flat),
`ifdef CONV_BIAS_EN
    .bias      (bias),
`endif
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data1),
    .out_sat   (out_sat[1]),
    .busy      (busy[1])
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int nt(input int w);
    return (w == 0) ? 9 : 3;
  endfunction

  // {sat, result sign-extended to 16 bits}: floor(sum / 2^SHIFT), clipped to OUT_W.
  function automatic logic [16:0] model(input int w);
    longint acc, d, q, hi, lo;
    int ow;
    acc = bias_v;
    for (int i = 0; i < NTAP; i++) acc += longint'(px[i]) * longint'(cf[i]);
    d  = (w == 0) ? 1 : 4;
    ow = (w == 0) ? 16 : 12;
    q  = acc / d;
    if ((acc % d != 0) && (acc < 0)) q -= 1;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    if (q > hi) return {1'b1, 16'(hi)};
    if (q < lo) return {1'b1, 16'(lo)};
    return {1'b0, 16'(q)};
  endfunction

  function automatic logic [15:0] got_data(input int w);
    if (w == 0) return out_data0;
    return {{4{out_data1[11]}}, out_data1};
  endfunction

  task automatic load();
    for (int i = 0; i < NTAP; i++) begin
      pix_flat[i*8 +: 8]  = 8'(px[i]);
      coef_flat[i*8 +: 8] = 8'(cf[i]);
    end
`ifdef CONV_BIAS_EN
    bias = 16'(bias_v);
`endif
  endtask

  task automatic check_result(input string tag, input int w, input logic [16:0] e);
    logic [15:0] d;
    d = got_data(w);
    check({tag, "_data"}, $signed(d), $signed(e[15:0]));
    check({tag, "_sat"}, out_sat[w], e[16]);
  endtask

  task automatic run_txn(input int w, input string tag);
    logic [16:0] e;
    int lat;
    e = model(w);
    load();
    check({tag, "_in_ready"}, in_ready[w], 1);
    in_valid[w] = 1'b1;
    @(posedge clk); #1;
    in_valid[w] = 1'b0;
    check({tag, "_busy"}, busy[w], 1);
    lat = 0;
    while (out_valid[w] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat + 1, nt(w) + 1);
    check_result(tag, w, e);
    if (out_ready[w]) begin
      @(posedge clk); #1;
      check({tag, "_release"}, {out_valid[w], in_ready[w], busy[w]}, 3'b010);
    end
  endtask

  task automatic fill(input int p, input int c);
    for (int i = 0; i < NTAP; i++) begin
      px[i] = p;
      cf[i] = c;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NTAP; i++) begin
      px[i] = int'($urandom_range(0, 255)) - 128;
      cf[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] e;
    int cyc, last, nacc;
    logic take;

    rst_n     = 1'b0;
    in_valid  = 2'b00;
    out_ready = 2'b11;
    bias_v    = 0;
    fill(0, 0);
    load();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 2'b11);
    check("rst_out_valid", out_valid, 2'b00);
    check("rst_busy", busy, 2'b00);
    check("rst_out_sat", out_sat, 2'b00);
    check("rst_out_data0", out_data0, 0);
    check("rst_out_data1", out_data1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill(1, 1);
    run_txn(0, "ones");
    fill(-128, 127);
    run_txn(0, "neg_sat");
    run_txn(1, "neg_sat_l3");
    fill(-128, -128);
    run_txn(0, "pos_sat");
    run_txn(1, "pos_sat_l3");

    fill(0, 0);
    for (int i = 0; i < NTAP; i++) px[i] = i + 1;
    cf[0] = 10;
    run_txn(1, "shift_pos");
    cf[0] = -10;
    run_txn(1, "shift_neg");

    for (int n = 0; n < 4; n++) begin
      fill_random();
      run_txn(0, "rand0");
      fill_random();
      run_txn(1, "rand1");
    end

    // Stall the LANES=3 engine in DONE and poke in_valid meanwhile.
    fill(0, 2);
    for (int i = 0; i < NTAP; i++) px[i] = i;
    out_ready[1] = 1'b0;
    run_txn(1, "stall");
    e = model(1);
    fill_random();
    load();
    in_valid[1] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid[1], 1);
      check("stall_in_ready", in_ready[1], 0);
      check_result("stall_hold", 1, e);
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    check("stall_release", {out_valid[1], in_ready[1], busy[1]}, 3'b010);

    // Asynchronous reset in RUN cycle 4.
    fill(1, 1);
    run_txn(0, "pre_rst");
    fill_random();
    load();
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready[0], 1);
    check("mid_rst_out_valid", out_valid[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_out_data", out_data0, 0);
    check("mid_rst_out_sat", out_sat[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", out_valid[0], 0);
    fill(1, 1);
    run_txn(0, "after_rst");

    // Back-to-back with in_valid held high and alternating kernels.
    fill_random();
    cfa = cf;
    fill_random();
    cfb = cf;
    cf = cfa;
    load();
    exp_q.delete();
    nacc = 0;
    last = -1;
    cyc  = 0;
    take = 1'b0;
    in_valid[0] = 1'b1;
    while ((nacc < 4 || exp_q.size() != 0) && cyc < 200) begin
      if (out_valid[0]) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_result("b2b", 0, e);
        end
      end
      if (in_ready[0] && in_valid[0]) begin
        exp_q.push_back(model(0));
        if (last >= 0) check("b2b_spacing", cyc - last, 11);
        last = cyc;
        nacc++;
        take = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (take) begin
        take = 1'b0;
        if (nacc % 2 == 1) cf = cfb;
        else cf = cfa;
        load();
        if (nacc == 4) in_valid[0] = 1'b0;
      end
    end
    in_valid[0] = 1'b0;
    check("b2b_accepts", nacc, 4);
    check("b2b_drained", exp_q.size(), 0);

`ifdef CONV_BIAS_EN
    bias_v = -9;
    fill(1, 1);
    run_txn(0, "bias");
    bias_v = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
